axi_id_restore: RTL and testbench

// Response-side companion to the AXI ID remapper. It records the slave-port AW/AR IDs at each

---
 rtl/axi_id_restore_if.sv | 67 ++++++
 rtl/axi_id_restore.sv | 134 +++++++++++++
 tb/tb_axi_id_restore.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axi_id_restore_if.sv
// axi_id_restore_if
// Handshake bundle for axi_id_restore: slave/master AW, AR address handshakes,
// B and R response handshakes, the restored IDs, outstanding counts and the
// sticky error flag. The _i/_o suffixes describe direction as seen by the
// restore block.
// Modports:
//   slave  - the restore block's view (consumes _i, drives _o)
//   master - the surrounding logic / driver view
interface axi_id_restore_if #(
  parameter int SlvIdWidth = 4,
  parameter int MaxTxns    = 8
);
  localparam int CntW = $clog2(MaxTxns + 1);

  logic [SlvIdWidth-1:0] slv_aw_id_i;
  logic                  slv_aw_valid_i;
  logic                  slv_aw_ready_o;
  logic                  mst_aw_valid_o;
  logic                  mst_aw_ready_i;

  logic [SlvIdWidth-1:0] slv_ar_id_i;
  logic                  slv_ar_valid_i;
  logic                  slv_ar_ready_o;
  logic                  mst_ar_valid_o;
  logic                  mst_ar_ready_i;

  logic                  mst_b_valid_i;
  logic                  mst_b_ready_o;
  logic                  slv_b_valid_o;
  logic                  slv_b_ready_i;
  logic [SlvIdWidth-1:0] slv_b_id_o;

  logic                  mst_r_valid_i;
  logic                  mst_r_ready_o;
  logic                  mst_r_last_i;
  logic                  slv_r_valid_o;
  logic                  slv_r_ready_i;
  logic [SlvIdWidth-1:0] slv_r_id_o;

  logic [CntW-1:0]       aw_cnt_o;
  logic [CntW-1:0]       ar_cnt_o;
  logic                  err_o;

  modport slave (
    input  slv_aw_id_i, slv_aw_valid_i, mst_aw_ready_i,
    output slv_aw_ready_o, mst_aw_valid_o,
    input  slv_ar_id_i, slv_ar_valid_i, mst_ar_ready_i,
    output slv_ar_ready_o, mst_ar_valid_o,
    input  mst_b_valid_i, slv_b_ready_i,
    output mst_b_ready_o, slv_b_valid_o, slv_b_id_o,
    input  mst_r_valid_i, mst_r_last_i, slv_r_ready_i,
    output mst_r_ready_o, slv_r_valid_o, slv_r_id_o,
    output aw_cnt_o, ar_cnt_o, err_o
  );

  modport master (
    output slv_aw_id_i, slv_aw_valid_i, mst_aw_ready_i,
    input  slv_aw_ready_o, mst_aw_valid_o,
    output slv_ar_id_i, slv_ar_valid_i, mst_ar_ready_i,
    input  slv_ar_ready_o, mst_ar_valid_o,
    output mst_b_valid_i, slv_b_ready_i,
    input  mst_b_ready_o, slv_b_valid_o, slv_b_id_o,
    output mst_r_valid_i, mst_r_last_i, slv_r_ready_i,
    input  mst_r_ready_o, slv_r_valid_o, slv_r_id_o,
    input  aw_cnt_o, ar_cnt_o, err_o
  );
endinterface

// File: rtl/axi_id_restore.sv
// axi_id_restore
// Records slave-port AW/AR IDs at each address handshake in a per-direction
// FIFO and presents the oldest one as the restored B/R ID. Responses come back
// in order because the master side uses one constant ID per direction.
// Ports:
//   clk_i - clock
//   rst_i - asynchronous reset, active high; discards all recorded IDs
//   bus   - axi_id_restore_if.slave: address/response handshakes, restored
//           IDs, outstanding counts, sticky err_o
// Direction index used internally: 0 = write (AW/B), 1 = read (AR/R).

// One ID FIFO per direction. Depth need not be a power of two, so the
// pointers wrap explicitly at Depth-1.
module axi_id_restore_fifo #(
  parameter int IdW   = 4,
  parameter int Depth = 8,
  parameter int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  logic [IdW-1:0]  push_id,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [IdW-1:0]  head,
  output logic [CntW-1:0] cnt
);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Depth-1:0][IdW-1:0] mem;
  logic [PW-1:0]             wptr, rptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (cnt == CntW'(Depth));
  assign empty = (cnt == '0);
  assign head  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      cnt <= cnt + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: it is only read through head while non-empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= push_id;
  end
endmodule

module axi_id_restore #(
  parameter int SlvIdWidth = 4,
  parameter int MaxTxns    = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  axi_id_restore_if.slave  bus
);
  localparam int CntW = $clog2(MaxTxns + 1);

  logic [1:0]                 req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_end;
  logic [1:0]                 push, pop, full, empty;
  logic [1:0][SlvIdWidth-1:0] push_id, head;
  logic [1:0][CntW-1:0]       cnt;
  logic                       err_q;

  assign req_vld = {bus.slv_ar_valid_i, bus.slv_aw_valid_i};
  assign req_rdy = {bus.mst_ar_ready_i, bus.mst_aw_ready_i};
  assign push_id = {bus.slv_ar_id_i,    bus.slv_aw_id_i};
  assign rsp_vld = {bus.mst_r_valid_i,  bus.mst_b_valid_i};
  assign rsp_rdy = {bus.slv_r_ready_i,  bus.slv_b_ready_i};
  // B is a single beat; an R burst only retires its ID on the last beat.
  assign rsp_end = {bus.mst_r_last_i,   1'b1};

  for (genvar d = 0; d < 2; d++) begin : g_dir
    // Full gates push regardless of a same-cycle pop (no full bypass).
    assign push[d] = req_vld[d] & req_rdy[d] & ~full[d];
    assign pop[d]  = rsp_vld[d] & rsp_rdy[d] & ~empty[d] & rsp_end[d];

    axi_id_restore_fifo #(
      .IdW  (SlvIdWidth),
      .Depth(MaxTxns),
      .CntW (CntW)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push   (push[d]),
      .push_id(push_id[d]),
      .pop    (pop[d]),
      .full   (full[d]),
      .empty  (empty[d]),
      .head   (head[d]),
      .cnt    (cnt[d])
    );
  end

  assign bus.mst_aw_valid_o = req_vld[0] & ~full[0];
  assign bus.slv_aw_ready_o = req_rdy[0] & ~full[0];
  assign bus.mst_ar_valid_o = req_vld[1] & ~full[1];
  assign bus.slv_ar_ready_o = req_rdy[1] & ~full[1];

  // Responses with nothing outstanding are held off, never accepted.
  assign bus.slv_b_valid_o  = rsp_vld[0] & ~empty[0];
  assign bus.mst_b_ready_o  = rsp_rdy[0] & ~empty[0];
  assign bus.slv_r_valid_o  = rsp_vld[1] & ~empty[1];
  assign bus.mst_r_ready_o  = rsp_rdy[1] & ~empty[1];

  assign bus.slv_b_id_o = head[0];
  assign bus.slv_r_id_o = head[1];
  assign bus.aw_cnt_o   = cnt[0];
  assign bus.ar_cnt_o   = cnt[1];
  assign bus.err_o      = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (|(rsp_vld & empty)) err_q <= 1'b1;
  end

  a_aw_cnt: assert property (@(posedge clk_i) disable iff (rst_i) cnt[0] <= CntW'(MaxTxns));
  a_ar_cnt: assert property (@(posedge clk_i) disable iff (rst_i) cnt[1] <= CntW'(MaxTxns));
  a_b_id:   assert property (@(posedge clk_i) disable iff (rst_i)
                             bus.slv_b_valid_o && !bus.slv_b_ready_i |=> $stable(bus.slv_b_id_o));
  a_r_id:   assert property (@(posedge clk_i) disable iff (rst_i)
                             bus.slv_r_valid_o && !bus.slv_r_ready_i |=> $stable(bus.slv_r_id_o));
endmodule

// File: tb/tb_axi_id_restore.sv
module tb_axi_id_restore;
  localparam int IdW = 4;
  localparam int MaxT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_id_restore_if #(.SlvIdWidth(IdW), .MaxTxns(MaxT)) bus ();

  axi_id_restore #(.SlvIdWidth(IdW), .MaxTxns(MaxT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding IDs are simply ordered lists.
  logic [IdW-1:0] aw_q[$];
  logic [IdW-1:0] ar_q[$];
  bit err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.slv_aw_id_i = '0; bus.slv_aw_valid_i = 0; bus.mst_aw_ready_i = 0;
    bus.slv_ar_id_i = '0; bus.slv_ar_valid_i = 0; bus.mst_ar_ready_i = 0;
    bus.mst_b_valid_i = 0; bus.slv_b_ready_i = 0;
    bus.mst_r_valid_i = 0; bus.mst_r_last_i = 0; bus.slv_r_ready_i = 0;
  endtask

  // Inputs are set just after a falling edge. Check all outputs against the
  // model, then advance one clock and update the model from the handshakes.
  task automatic cycle();
    bit aw_full, ar_full, b_emp, r_emp, do_aw, do_ar, do_b, do_r;
    #1;
    aw_full = (aw_q.size() == MaxT);
    ar_full = (ar_q.size() == MaxT);
    b_emp   = (aw_q.size() == 0);
    r_emp   = (ar_q.size() == 0);
    chk("mst_aw_valid", 32'(bus.mst_aw_valid_o), 32'(bus.slv_aw_valid_i && !aw_full));
    chk("slv_aw_ready", 32'(bus.slv_aw_ready_o), 32'(bus.mst_aw_ready_i && !aw_full));
    chk("mst_ar_valid", 32'(bus.mst_ar_valid_o), 32'(bus.slv_ar_valid_i && !ar_full));
    chk("slv_ar_ready", 32'(bus.slv_ar_ready_o), 32'(bus.mst_ar_ready_i && !ar_full));
    chk("slv_b_valid",  32'(bus.slv_b_valid_o),  32'(bus.mst_b_valid_i && !b_emp));
    chk("mst_b_ready",  32'(bus.mst_b_ready_o),  32'(bus.slv_b_ready_i && !b_emp));
    chk("slv_r_valid",  32'(bus.slv_r_valid_o),  32'(bus.mst_r_valid_i && !r_emp));
    chk("mst_r_ready",  32'(bus.mst_r_ready_o),  32'(bus.slv_r_ready_i && !r_emp));
    chk("slv_b_id",     32'(bus.slv_b_id_o),     b_emp ? 32'd0 : 32'(aw_q[0]));
    chk("slv_r_id",     32'(bus.slv_r_id_o),     r_emp ? 32'd0 : 32'(ar_q[0]));
    chk("aw_cnt",       32'(bus.aw_cnt_o),       32'(aw_q.size()));
    chk("ar_cnt",       32'(bus.ar_cnt_o),       32'(ar_q.size()));
    chk("err",          32'(bus.err_o),          32'(err_m));
    do_aw = bus.slv_aw_valid_i && bus.mst_aw_ready_i && !aw_full;
    do_ar = bus.slv_ar_valid_i && bus.mst_ar_ready_i && !ar_full;
    do_b  = bus.mst_b_valid_i && bus.slv_b_ready_i && !b_emp;
    do_r  = bus.mst_r_valid_i && bus.slv_r_ready_i && bus.mst_r_last_i && !r_emp;
    if ((bus.mst_b_valid_i && b_emp) || (bus.mst_r_valid_i && r_emp)) err_m = 1'b1;
    @(posedge clk);
    if (do_b) void'(aw_q.pop_front());
    if (do_r) void'(ar_q.pop_front());
    if (do_aw) aw_q.push_back(bus.slv_aw_id_i);
    if (do_ar) ar_q.push_back(bus.slv_ar_id_i);
    @(negedge clk);
  endtask

  task automatic aw(input logic [IdW-1:0] id);
    idle(); bus.slv_aw_id_i = id; bus.slv_aw_valid_i = 1; bus.mst_aw_ready_i = 1; cycle();
  endtask

  task automatic ar(input logic [IdW-1:0] id);
    idle(); bus.slv_ar_id_i = id; bus.slv_ar_valid_i = 1; bus.mst_ar_ready_i = 1; cycle();
  endtask

  task automatic b_rsp();
    idle(); bus.mst_b_valid_i = 1; bus.slv_b_ready_i = 1; cycle();
  endtask

  task automatic r_rsp(input bit last);
    idle(); bus.mst_r_valid_i = 1; bus.slv_r_ready_i = 1; bus.mst_r_last_i = last; cycle();
  endtask

  initial begin
    idle();
    // Reset state
    @(negedge clk); #1;
    chk("rst_aw_cnt", 32'(bus.aw_cnt_o), 0);
    chk("rst_ar_cnt", 32'(bus.ar_cnt_o), 0);
    chk("rst_err",    32'(bus.err_o), 0);
    chk("rst_b_id",   32'(bus.slv_b_id_o), 0);
    @(negedge clk);
    rst = 0;
    idle(); cycle();

    // AW IDs 3,7,1 then three B responses, in order
    aw(4'd3); aw(4'd7); aw(4'd1);
    chk("t2_cnt3", 32'(bus.aw_cnt_o), 3);
    chk("t2_head3", 32'(bus.slv_b_id_o), 3);
    b_rsp(); chk("t2_head7", 32'(bus.slv_b_id_o), 7);
    b_rsp(); chk("t2_head1", 32'(bus.slv_b_id_o), 1);
    b_rsp(); chk("t2_cnt0", 32'(bus.aw_cnt_o), 0);

    // Fill AR to MaxTxns, 9th blocked until an R last
    for (int i = 0; i < MaxT; i++) ar(4'(i + 8));
    chk("t3_full", 32'(bus.ar_cnt_o), MaxT);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.slv_ar_id_i = 4'hF; bus.slv_ar_valid_i = 1; bus.mst_ar_ready_i = 1;
      #1;
      chk("t3_blk_valid", 32'(bus.mst_ar_valid_o), 0);
      chk("t3_blk_ready", 32'(bus.slv_ar_ready_o), 0);
      cycle();
    end
    // R last with the 9th AR still presented: pop happens, push still blocked
    bus.mst_r_valid_i = 1; bus.slv_r_ready_i = 1; bus.mst_r_last_i = 1;
    cycle();
    chk("t3_after_pop", 32'(bus.ar_cnt_o), MaxT - 1);
    ar(4'hF);
    chk("t3_refill", 32'(bus.ar_cnt_o), MaxT);
    while (ar_q.size() > 0) r_rsp(1'b1);

    // AR ID 5, 4-beat burst
    ar(4'd5);
    for (int b = 0; b < 4; b++) begin
      idle(); bus.mst_r_valid_i = 1; bus.slv_r_ready_i = 1; bus.mst_r_last_i = (b == 3);
      #1;
      chk("t4_beat_id", 32'(bus.slv_r_id_o), 5);
      chk("t4_beat_cnt", 32'(bus.ar_cnt_o), 1);
      cycle();
    end
    chk("t4_cnt0", 32'(bus.ar_cnt_o), 0);

    // Same-cycle push and pop at count 4
    aw(4'd10); aw(4'd11); aw(4'd12); aw(4'd13);
    idle(); bus.slv_aw_id_i = 4'd2; bus.slv_aw_valid_i = 1; bus.mst_aw_ready_i = 1;
    bus.mst_b_valid_i = 1; bus.slv_b_ready_i = 1;
    cycle();
    chk("t5_cnt4", 32'(bus.aw_cnt_o), 4);
    chk("t5_head", 32'(bus.slv_b_id_o), 11);
    while (aw_q.size() > 0) b_rsp();

    // B response with empty FIFO
    idle(); bus.mst_b_valid_i = 1; bus.slv_b_ready_i = 1;
    #1;
    chk("t6_ready", 32'(bus.mst_b_ready_o), 0);
    chk("t6_valid", 32'(bus.slv_b_valid_o), 0);
    chk("t6_err_pre", 32'(bus.err_o), 0);
    cycle();
    idle(); #1;
    chk("t6_err", 32'(bus.err_o), 1);
    cycle();

    // Reset mid-stream with 3 AW outstanding
    aw(4'd4); aw(4'd6); aw(4'd9);
    idle(); bus.mst_b_valid_i = 1;
    rst = 1; #1;
    aw_q.delete(); ar_q.delete(); err_m = 0;
    chk("t1_cnt", 32'(bus.aw_cnt_o), 0);
    chk("t1_bvalid", 32'(bus.slv_b_valid_o), 0);
    chk("t1_err", 32'(bus.err_o), 0);
    @(negedge clk);
    idle(); rst = 0;
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bus.slv_aw_id_i    = 4'($urandom);
      bus.slv_aw_valid_i = ($urandom_range(0, 2) != 0);
      bus.mst_aw_ready_i = ($urandom_range(0, 3) != 0);
      bus.slv_ar_id_i    = 4'($urandom);
      bus.slv_ar_valid_i = ($urandom_range(0, 2) != 0);
      bus.mst_ar_ready_i = ($urandom_range(0, 3) != 0);
      bus.mst_b_valid_i  = ($urandom_range(0, 2) == 0) && (aw_q.size() > 0 || n > 580);
      bus.slv_b_ready_i  = ($urandom_range(0, 2) != 0);
      bus.mst_r_valid_i  = ($urandom_range(0, 1) == 0) && (ar_q.size() > 0);
      bus.mst_r_last_i   = ($urandom_range(0, 2) == 0);
      bus.slv_r_ready_i  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
